// File: rtl/ami.sv
// ami: single-outstanding AXI4 master bridging a simple command / data-stream
// user interface onto the five AXI4 channels (INCR bursts, full-width beats).
// Optional build macro: AMI_4KB_CHECK_EN -- reject bursts that would cross a
// 4 KB boundary, reporting SLVERR without touching the AXI bus.
module ami #(
    parameter int AXI_DW = 128,
    parameter int AXI_AW = 40,
    parameter int AXI_IW = 8,
    parameter int AXI_LW = 8
) (
    input  logic                ACLK,
    input  logic                ARESET,
    // command interface
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [AXI_AW-1:0]   cmd_addr,
    input  logic [AXI_LW-1:0]   cmd_len,
    input  logic [AXI_IW-1:0]   cmd_id,
    // user write-data stream
    input  logic [AXI_DW-1:0]   usr_wdata,
    input  logic [AXI_DW/8-1:0] usr_wstrb,
    input  logic                usr_wvalid,
    output logic                usr_wready,
    // user read-data stream
    output logic [AXI_DW-1:0]   usr_rdata,
    output logic                usr_rvalid,
    input  logic                usr_rready,
    // completion
    output logic                done,
    output logic [1:0]          done_resp,
    // AXI write address
    output logic [AXI_IW-1:0]   AWID,
    output logic [AXI_AW-1:0]   AWADDR,
    output logic [AXI_LW-1:0]   AWLEN,
    output logic [2:0]          AWSIZE,
    output logic [1:0]          AWBURST,
    output logic                AWVALID,
    input  logic                AWREADY,
    // AXI write data
    output logic [AXI_DW-1:0]   WDATA,
    output logic [AXI_DW/8-1:0] WSTRB,
    output logic                WLAST,
    output logic                WVALID,
    input  logic                WREADY,
    // AXI write response
    input  logic [AXI_IW-1:0]   BID,
    input  logic [1:0]          BRESP,
    input  logic                BVALID,
    output logic                BREADY,
    // AXI read address
    output logic [AXI_IW-1:0]   ARID,
    output logic [AXI_AW-1:0]   ARADDR,
    output logic [AXI_LW-1:0]   ARLEN,
    output logic [2:0]          ARSIZE,
    output logic [1:0]          ARBURST,
    output logic                ARVALID,
    input  logic                ARREADY,
    // AXI read data
    input  logic [AXI_IW-1:0]   RID,
    input  logic [AXI_DW-1:0]   RDATA,
    input  logic [1:0]          RRESP,
    input  logic                RLAST,
    input  logic                RVALID,
    output logic                RREADY
);

    localparam int         SIZE   = $clog2(AXI_DW / 8);
    localparam logic [2:0] AXSIZE = 3'(SIZE);

    typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE} state_t;

    state_t              state_q, state_d;
    logic                write_q, write_d;
    logic [AXI_AW-1:0]   addr_q,  addr_d;
    logic [AXI_LW-1:0]   len_q,   len_d;
    logic [AXI_IW-1:0]   id_q,    id_d;
    logic [AXI_LW-1:0]   cnt_q,   cnt_d;
    logic [1:0]          resp_q,  resp_d;
    logic [1:0]          rd_resp;
    logic                cnt_at_len;
    logic                in_w;
    logic                in_r;

    // Responses rank numerically: OKAY < EXOKAY < SLVERR < DECERR.
    function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    assign cnt_at_len = (cnt_q == len_q);
    assign in_w       = (state_q == S_W);
    assign in_r       = (state_q == S_R);

`ifdef AMI_4KB_CHECK_EN
    logic [31:0] end_off;
    assign end_off = 32'(cmd_addr[11:0]) + ((32'(cmd_len) + 32'd1) << SIZE);
`endif

    // State and command registers; synchronous reset abandons any burst.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= S_IDLE;
            write_q <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
            resp_q  <= '0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
        end
    end

    // Next-state, beat counting and response accumulation.
    always_comb begin
        state_d = state_q;
        write_d = write_q;
        addr_d  = addr_q;
        len_d   = len_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        resp_d  = resp_q;
        rd_resp = '0;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    write_d = cmd_write;
                    addr_d  = cmd_addr;
                    len_d   = cmd_len;
                    id_d    = cmd_id;
                    resp_d  = 2'b00;
                    state_d = cmd_write ? S_AW : S_AR;
`ifdef AMI_4KB_CHECK_EN
                    if (end_off > 32'd4096) begin
                        resp_d  = 2'b10;
                        state_d = S_DONE;
                    end
`endif
                end
            end
            S_AW: begin
                if (AWREADY) begin
                    cnt_d   = '0;
                    state_d = S_W;
                end
            end
            S_W: begin
                if (usr_wvalid && WREADY) begin
                    cnt_d = cnt_q + AXI_LW'(1);
                    if (cnt_at_len) state_d = S_B;
                end
            end
            S_B: begin
                if (BVALID) begin
                    resp_d  = (BID != id_q) ? worst(BRESP, 2'b10) : BRESP;
                    state_d = S_DONE;
                end
            end
            S_AR: begin
                if (ARREADY) begin
                    cnt_d   = '0;
                    state_d = S_R;
                end
            end
            S_R: begin
                if (RVALID && usr_rready) begin
                    cnt_d   = cnt_q + AXI_LW'(1);
                    rd_resp = worst(resp_q, RRESP);
                    // RLAST must coincide exactly with the final counted beat.
                    if ((RID != id_q) || (RLAST != cnt_at_len)) rd_resp = worst(rd_resp, 2'b10);
                    resp_d  = rd_resp;
                    if (RLAST || cnt_at_len) state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign cmd_ready  = (state_q == S_IDLE) && !ARESET;

    assign AWID       = id_q;
    assign AWADDR     = addr_q;
    assign AWLEN      = len_q;
    assign AWSIZE     = AXSIZE;
    assign AWBURST    = 2'b01;
    assign AWVALID    = (state_q == S_AW);

    assign WVALID     = in_w && usr_wvalid;
    assign usr_wready = in_w && WREADY;
    assign WDATA      = in_w ? usr_wdata : '0;
    assign WSTRB      = in_w ? usr_wstrb : '0;
    assign WLAST      = in_w && cnt_at_len;

    assign BREADY     = (state_q == S_B);

    assign ARID       = id_q;
    assign ARADDR     = addr_q;
    assign ARLEN      = len_q;
    assign ARSIZE     = AXSIZE;
    assign ARBURST    = 2'b01;
    assign ARVALID    = (state_q == S_AR);

    assign usr_rvalid = in_r && RVALID;
    assign RREADY     = in_r && usr_rready;
    assign usr_rdata  = in_r ? RDATA : '0;

    assign done       = (state_q == S_DONE);
    assign done_resp  = done ? resp_q : 2'b00;

endmodule

// File: tb/tb_ami.sv
// tb_ami: scoreboard bench for ami acting as both user and AXI slave.
// Honours AMI_4KB_CHECK_EN when the same macro is defined for the build.
module tb_ami;

    typedef struct packed {
        logic        last;
        logic [15:0] strb;
        logic [127:0] data;
    } wbeat_t;

    logic         ACLK, ARESET;
    logic         cmd_valid, cmd_ready, cmd_write;
    logic [39:0]  cmd_addr;
    logic [7:0]   cmd_len, cmd_id;
    logic [127:0] usr_wdata, usr_rdata;
    logic [15:0]  usr_wstrb;
    logic         usr_wvalid, usr_wready, usr_rvalid, usr_rready;
    logic         done;
    logic [1:0]   done_resp;
    logic [7:0]   AWID, ARID, BID, RID, AWLEN, ARLEN;
    logic [39:0]  AWADDR, ARADDR;
    logic [2:0]   AWSIZE, ARSIZE;
    logic [1:0]   AWBURST, ARBURST, BRESP, RRESP;
    logic         AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic         ARVALID, ARREADY, RLAST, RVALID, RREADY;
    logic [127:0] WDATA, RDATA;
    logic [15:0]  WSTRB;

    int         n_checks = 0;
    int         n_errors = 0;
    int         aw_dly, rerr_beat, rlast_beat, abort_beat;
    logic [1:0] bresp_k;
    logic       bid_bad, rtoggle, hold_cmd;

    wbeat_t       wq[$];
    logic [127:0] rq[$];
    logic [1:0]   respq[$];

    ami #(.AXI_DW(128), .AXI_AW(40), .AXI_IW(8), .AXI_LW(8)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
        .usr_wdata(usr_wdata), .usr_wstrb(usr_wstrb), .usr_wvalid(usr_wvalid),
        .usr_wready(usr_wready), .usr_rdata(usr_rdata), .usr_rvalid(usr_rvalid),
        .usr_rready(usr_rready), .done(done), .done_resp(done_resp),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
        .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID),
        .RREADY(RREADY)
    );

    // 100 MHz clock
    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    task automatic check(input string tag, input logic [143:0] obs, input logic [143:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] wdat(input logic [7:0] id, input int i);
        return {24'hC0DE00, id, 32'(i) * 32'h01010101, 32'hA5A50000 + 32'(i), ~32'(i)};
    endfunction

    function automatic logic [15:0] wstrb_of(input int i);
        logic [3:0] sh;
        sh = i[3:0];
        return 16'hFFFF ^ (16'h0001 << sh);
    endfunction

    function automatic logic [127:0] rdat(input logic [39:0] a, input int i);
        return {a[31:0], 32'(i), 32'hBEEF0000 ^ 32'(i), ~32'(i)};
    endfunction

    task automatic set_defaults();
        aw_dly     = 0;
        rerr_beat  = -1;
        rlast_beat = -1;
        abort_beat = -1;
        bresp_k    = 2'b00;
        bid_bad    = 1'b0;
        rtoggle    = 1'b0;
        hold_cmd   = 1'b0;
    endtask

    // One command end to end: user side, AXI slave side and scoreboards.
    task automatic run_cmd(input logic wr, input logic [39:0] addr, input logic [7:0] len,
                           input logic [7:0] id, input logic [1:0] exp_resp, input logic skip);
        int     cyc, aw_cnt, ui, rb, post, whs, rl, nbeats;
        logic   accepted, saw_aw, saw_ar, b_pend, r_active, finished, aborted, rtog;
        wbeat_t e;
        cyc = 0; aw_cnt = 0; ui = 0; rb = 0; post = 0; whs = 0;
        accepted = 0; saw_aw = 0; saw_ar = 0; b_pend = 0;
        r_active = 0; finished = 0; aborted = 0; rtog = 0;
        rl = (rlast_beat < 0) ? int'(len) : rlast_beat;
        if (!skip) begin
            if (wr) begin
                for (int i = 0; i <= int'(len); i++)
                    wq.push_back('{last: (i == int'(len)), strb: wstrb_of(i), data: wdat(id, i)});
            end else begin
                nbeats = ((rl < int'(len)) ? rl : int'(len)) + 1;
                for (int i = 0; i < nbeats; i++) rq.push_back(rdat(addr, i));
            end
        end
        if (abort_beat < 0) respq.push_back(exp_resp);
        cmd_write = wr; cmd_addr = addr; cmd_len = len; cmd_id = id;
        while (!finished && cyc < 300) begin
            @(negedge ACLK);
            cyc++;
            cmd_valid  = !accepted || hold_cmd;
            AWREADY    = (aw_cnt >= aw_dly);
            ARREADY    = (aw_cnt >= aw_dly);
            usr_wvalid = wr && (ui <= int'(len));
            usr_wdata  = wdat(id, ui);
            usr_wstrb  = wstrb_of(ui);
            WREADY     = ($urandom_range(0, 3) != 0);
            BVALID     = b_pend;
            BID        = bid_bad ? ~id : id;
            BRESP      = bresp_k;
            RVALID     = r_active && ($urandom_range(0, 3) != 0);
            RDATA      = rdat(addr, rb);
            RLAST      = (rb == rl);
            RRESP      = (rb == rerr_beat) ? 2'b10 : 2'b00;
            RID        = id;
            rtog       = ~rtog;
            usr_rready = rtoggle ? rtog : 1'b1;
            ARESET     = 1'b0;
            if (abort_beat >= 0 && !aborted && whs == abort_beat) begin
                ARESET  = 1'b1;
                WREADY  = 1'b0;
                aborted = 1'b1;
            end
            #1;
            if (ARESET) continue;
            if (aborted) begin
                if (post == 0) begin
                    check("abort_wvalid", WVALID, 0);
                    check("abort_usr_wready", usr_wready, 0);
                    check("abort_cmd_ready", cmd_ready, 1);
                end
                check("abort_no_done", done, 0);
                post++;
                if (post == 5) begin
                    finished = 1;
                    wq.delete();
                end
                continue;
            end
            if (cmd_valid && cmd_ready && !accepted) begin
                check("cmd_wait", cyc, 1);
                accepted = 1;
            end
            if (AWVALID) begin
                if (!saw_aw) begin
                    check("aw_addr", AWADDR, addr);
                    check("aw_len", AWLEN, len);
                    check("aw_id", AWID, id);
                    check("aw_size", AWSIZE, 3'd4);
                    check("aw_burst", AWBURST, 2'b01);
                end
                saw_aw = 1;
                if (AWREADY) check("aw_wait", aw_cnt, aw_dly);
                else aw_cnt++;
            end
            if (ARVALID) begin
                if (!saw_ar) begin
                    check("ar_addr", ARADDR, addr);
                    check("ar_len", ARLEN, len);
                    check("ar_id", ARID, id);
                    check("ar_size", ARSIZE, 3'd4);
                    check("ar_burst", ARBURST, 2'b01);
                end
                saw_ar = 1;
                if (ARREADY) r_active = 1;
                else aw_cnt++;
            end
            if (WVALID) check("w_ready_mirror", usr_wready, WREADY);
            if (WVALID && WREADY) begin
                if (wq.size() == 0) check("w_extra_beat", 1, 0);
                else begin
                    e = wq.pop_front();
                    check("w_data", WDATA, e.data);
                    check("w_strb", WSTRB, e.strb);
                    check("w_last", WLAST, e.last);
                    if (WLAST) b_pend = 1;
                end
                whs++;
            end
            if (usr_wvalid && usr_wready) ui++;
            if (BVALID && BREADY) b_pend = 0;
            if (r_active && !done && !ARVALID) check("r_ready_mirror", RREADY, usr_rready);
            if (usr_rvalid && usr_rready) begin
                if (rq.size() == 0) check("r_extra_beat", 1, 0);
                else check("r_data", usr_rdata, rq.pop_front());
            end
            if (RVALID && RREADY) rb++;
            if (done) begin
                if (respq.size() == 0) check("done_unexpected", 1, 0);
                else check("done_resp", done_resp, respq.pop_front());
                check("done_blocks_cmd", cmd_ready, 0);
                finished = 1;
                r_active = 0;
                b_pend   = 0;
            end
        end
        check("completed", finished, 1);
        check("wq_empty", wq.size(), 0);
        check("rq_empty", rq.size(), 0);
        if (skip) check("no_axi", {saw_aw, saw_ar}, 2'b00);
        else if (abort_beat < 0) check("axi_issued", wr ? saw_aw : saw_ar, 1);
        wq.delete();
        rq.delete();
        respq.delete();
    endtask

    initial begin
        logic skip4k;
        logic [1:0] r4k;
        ARESET = 1'b1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0; cmd_id = '0;
        usr_wdata = '0; usr_wstrb = '0; usr_wvalid = 0; usr_rready = 0;
        AWREADY = 0; WREADY = 0; BID = '0; BRESP = '0; BVALID = 0;
        ARREADY = 0; RID = '0; RDATA = '0; RRESP = '0; RLAST = 0; RVALID = 0;
        set_defaults();
        repeat (2) @(posedge ACLK);
        @(negedge ACLK); #1;
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_awvalid", AWVALID, 0);
        check("rst_wvalid", WVALID, 0);
        check("rst_arvalid", ARVALID, 0);
        check("rst_bready", BREADY, 0);
        check("rst_rready", RREADY, 0);
        check("rst_usr_wready", usr_wready, 0);
        check("rst_usr_rvalid", usr_rvalid, 0);
        check("rst_done", {done, done_resp}, 3'b000);
        @(negedge ACLK);
        ARESET = 1'b0;
        #1;
        check("rst_release_ready", cmd_ready, 1);

        // write, AWREADY two cycles late
        set_defaults(); aw_dly = 2;
        run_cmd(1'b1, 40'h100, 8'd3, 8'h11, 2'b00, 1'b0);
        // read with usr_rready toggling
        set_defaults(); rtoggle = 1'b1;
        run_cmd(1'b0, 40'h200, 8'd7, 8'h22, 2'b00, 1'b0);
        // SLVERR on one beat
        set_defaults(); rerr_beat = 2;
        run_cmd(1'b0, 40'h240, 8'd3, 8'h23, 2'b10, 1'b0);
        // early RLAST
        set_defaults(); rlast_beat = 1;
        run_cmd(1'b0, 40'h280, 8'd3, 8'h24, 2'b10, 1'b0);
        // missing RLAST on final counted beat
        set_defaults(); rlast_beat = 9;
        run_cmd(1'b0, 40'h2C0, 8'd1, 8'h25, 2'b10, 1'b0);
        // reset during W beat 2 of 4
        set_defaults(); abort_beat = 1;
        run_cmd(1'b1, 40'h500, 8'd3, 8'h33, 2'b00, 1'b0);
        // burst ending exactly on a 4 KB boundary is always issued
        set_defaults();
        run_cmd(1'b1, 40'hFE0, 8'd1, 8'h44, 2'b00, 1'b0);
        // burst crossing a 4 KB boundary
`ifdef AMI_4KB_CHECK_EN
        skip4k = 1'b1; r4k = 2'b10;
`else
        skip4k = 1'b0; r4k = 2'b01;
`endif
        set_defaults(); bresp_k = 2'b01;
        run_cmd(1'b1, 40'hFF0, 8'd1, 8'h45, r4k, skip4k);
        // back-to-back write (bad BID) then read with cmd_valid held
        set_defaults(); hold_cmd = 1'b1; bid_bad = 1'b1;
        run_cmd(1'b1, 40'h300, 8'd0, 8'h55, 2'b10, 1'b0);
        set_defaults();
        run_cmd(1'b0, 40'h404, 8'd2, 8'h56, 2'b00, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
